mvm_stream_core: RTL and testbench

//  Parametrised N x N signed matrix-vector multiply engine, y = W*x, for the tt_um_mvm_ tile.

---
 rtl/mvm_pkg.sv | 35 +++
 rtl/mvm_mac.sv | 29 ++
 rtl/mvm_stream_core.sv | 140 ++++++++++++++
 tb/tb_mvm_stream_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared state type, stream mode codes and result formatting for mvm_stream_core.
// Optional feature: define MVM_SAT_EN to saturate results instead of truncating them.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN
    } state_t;

    localparam logic [1:0] MODE_NOP = 2'b00;
    localparam logic [1:0] MODE_WGT = 2'b01;
    localparam logic [1:0] MODE_VEC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    // Wide enough for any legal accumulator; callers sign-extend into it.
    localparam int FMT_W = 32;

    // Maps a result onto an out_w-bit word (low out_w bits of the return value).
    function automatic logic signed [FMT_W-1:0] sat_trunc(
        input logic signed [FMT_W-1:0] acc,
        input int                      out_w
    );
        logic signed [FMT_W-1:0] hi;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
`ifdef MVM_SAT_EN
        if (acc > hi) return hi;
        if (acc < -hi - 32'sd1) return -hi - 32'sd1;
        return acc;
`else
        return acc & ((hi <<< 1) | 32'sd1);
`endif
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// Registered signed multiply-accumulate; clr and en together load a fresh product.
module mvm_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = a * b;

    // NOTE: clocked state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr || en) begin
            acc <= (clr ? '0 : acc) + (en ? ACC_W'(prod) : '0);
        end
    end

endmodule

// File: rtl/mvm_stream_core.sv
// Byte-streamed N x N signed matrix-vector multiply (y = W*x), one MAC per cycle.
// Optional feature: MVM_SAT_EN selects saturating instead of truncating result words.
module mvm_stream_core
    import mvm_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(N),
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [1:0]               in_mode,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int NN   = N * N;
    localparam int WP_W = $clog2(NN);
    localparam int XP_W = $clog2(N);
    localparam logic [XP_W-1:0] LAST = XP_W'(N - 1);

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  w_mem [NN];
    logic signed [DATA_W-1:0]  x_mem [N];
    logic signed [ACC_W-1:0]   y_mem [N];
    logic [WP_W-1:0]           wptr, widx;
    logic [XP_W-1:0]           xptr, row, col, wb_row, out_idx;
    logic                      issuing, wb_valid;
    logic                      in_fire, out_fire, mac_en, mac_clr;
    logic signed [ACC_W-1:0]   mac_acc;

    assign in_ready  = ena && rst_n && (state_q == IDLE);
    assign out_valid = ena && (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = out_valid ? OUT_W'(sat_trunc(FMT_W'(y_mem[out_idx]), OUT_W)) : '0;

    assign widx    = WP_W'(row * N) + WP_W'(col);
    assign mac_en  = ena && issuing && (state_q == COMPUTE);
    assign mac_clr = mac_en && (col == '0);

    mvm_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (w_mem[widx]),
        .b     (x_mem[col]),
        .acc   (mac_acc)
    );

    // NOTE: state_d gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_fire && in_mode == MODE_VEC && xptr == LAST) state_d = COMPUTE;
            COMPUTE: if (wb_valid && wb_row == LAST)                     state_d = DRAIN;
            DRAIN:   if (out_fire && out_idx == LAST)                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each finished row is written back one cycle after its last MAC, so COMPUTE
    // spans N*N MAC cycles plus one write-back cycle for the final row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr     <= '0;
            xptr     <= '0;
            row      <= '0;
            col      <= '0;
            wb_row   <= '0;
            out_idx  <= '0;
            issuing  <= 1'b0;
            wb_valid <= 1'b0;
            // NOTE: the operand and result arrays are cleared on reset because a
            // vector issued before any weight load must multiply by an all-zero W.
            for (int i = 0; i < NN; i++) w_mem[i] <= '0;
            for (int i = 0; i < N; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
        end else if (ena) begin
            state_q  <= state_d;
            wb_valid <= 1'b0;
            case (state_q)
                IDLE: if (in_fire) begin
                    unique case (in_mode)
                        MODE_WGT: begin
                            w_mem[wptr] <= in_data;
                            wptr <= (wptr == WP_W'(NN - 1)) ? '0 : wptr + WP_W'(1);
                        end
                        MODE_VEC: begin
                            x_mem[xptr] <= in_data;
                            if (xptr == LAST) begin
                                xptr    <= '0;
                                row     <= '0;
                                col     <= '0;
                                issuing <= 1'b1;
                            end else begin
                                xptr <= xptr + XP_W'(1);
                            end
                        end
                        MODE_CLR: begin
                            wptr <= '0;
                            xptr <= '0;
                        end
                        default: ;
                    endcase
                end
                COMPUTE: begin
                    if (issuing) begin
                        if (col == LAST) begin
                            col      <= '0;
                            wb_valid <= 1'b1;
                            wb_row   <= row;
                            if (row == LAST) issuing <= 1'b0;
                            else             row     <= row + XP_W'(1);
                        end else begin
                            col <= col + XP_W'(1);
                        end
                    end
                    if (wb_valid) y_mem[wb_row] <= mac_acc;
                end
                DRAIN: if (out_fire) out_idx <= (out_idx == LAST) ? '0 : out_idx + XP_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_stream_core.sv
// Directed bench for mvm_stream_core: a matrix/vector model feeds an expected-result queue
// checked every valid cycle, plus hand-computed literal expectations for key vectors.
module tb_mvm_stream_core;

    logic       clk, rst_n, ena;
    logic [1:0] in_mode;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, busy;

    int n_vec  = 0;
    int n_miss = 0;

    int         mw [16];
    int         mx [4];
    int         m_wptr, m_xptr;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    time        t_last;

    mvm_stream_core #(.N(4), .DATA_W(8), .OUT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fmt(input int y);
`ifdef MVM_SAT_EN
        if (y > 127)  return 8'h7f;
        if (y < -128) return 8'h80;
`endif
        return y[7:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mw[i] = 0;
        for (int i = 0; i < 4; i++)  mx[i] = 0;
        m_wptr = 0;
        m_xptr = 0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic [1:0] mode, input int data);
        int y;
        case (mode)
            2'b01: begin
                mw[m_wptr] = data;
                m_wptr = (m_wptr + 1) % 16;
            end
            2'b10: begin
                mx[m_xptr] = data;
                if (m_xptr == 3) begin
                    for (int i = 0; i < 4; i++) begin
                        y = 0;
                        for (int k = 0; k < 4; k++) y += mw[i*4 + k] * mx[k];
                        exp_q.push_back(fmt(y));
                    end
                    m_xptr = 0;
                end else begin
                    m_xptr++;
                end
            end
            2'b11: begin
                m_wptr = 0;
                m_xptr = 0;
            end
            default: ;
        endcase
    endfunction

    task automatic beat(input logic [1:0] mode, input int data);
        int guard = 0;
        in_mode  = mode;
        in_data  = data[7:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        t_last = $time;
        model_beat(mode, data);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_vec(input int a, input int b, input int c, input int d);
        beat(2'b10, a);
        beat(2'b10, b);
        beat(2'b10, c);
        beat(2'b10, d);
    endtask

    task automatic fill_w(input int v);
        for (int i = 0; i < 16; i++) beat(2'b01, v);
    endtask

    task automatic measure_latency(input string name, input int exp_lat);
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(name, ($time - 5 - t_last) / 10, exp_lat);
    endtask

    task automatic wait_drained();
        int guard = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        check({name, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check(name, (i < got_q.size()) ? got_q[i] : 8'hxx, e[i]);
        got_q.delete();
    endtask

    // Output monitor: every valid cycle must show the oldest outstanding result,
    // and a stalled beat must stay valid and unchanged until it is taken.
    initial begin : compare
        logic       stall_pend;
        logic [7:0] stall_data;
        stall_pend = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
            end else if (ena) begin
                if (stall_pend) begin
                    check("stall_valid_held", {63'd0, out_valid}, 64'd1);
                    check("stall_data_held", out_data, stall_data);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("extra_result", 64'd1, 64'd0);
                    end else begin
                        check("out_data", out_data, exp_q[0]);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                    if (out_ready) got_q.push_back(out_data);
                end
                stall_pend = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] e_big, e_neg, e_242, e_150;
`ifdef MVM_SAT_EN
        e_big = 8'h7f; e_neg = 8'h80; e_242 = 8'h7f; e_150 = 8'h7f;
`else
        e_big = 8'h04; e_neg = 8'h00; e_242 = 8'hf2; e_150 = 8'h96;
`endif
        rst_n = 1'b0; ena = 1'b1; in_mode = 2'b00; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Vector against the reset (all-zero) weights
        send_vec(1, 2, 3, 4);
        wait_drained();
        check_got("zero_w", 8'd0, 8'd0, 8'd0, 8'd0);

        // Identity weights with latency measurement
        for (int i = 0; i < 16; i++) beat(2'b01, (i % 5 == 0) ? 1 : 0);
        send_vec(1, 2, 3, 4);
        measure_latency("latency_17", 17);
        wait_drained();
        check_got("identity", 8'd1, 8'd2, 8'd3, 8'd4);

        // Large positive and large negative sums
        fill_w(127);
        send_vec(127, 127, 127, 127);
        wait_drained();
        check_got("pos_64516", e_big, e_big, e_big, e_big);
        fill_w(-128);
        send_vec(127, 127, 127, 127);
        wait_drained();
        check_got("neg_65024", e_neg, e_neg, e_neg, e_neg);

        // Weight pointer wrap: 17 beats leave W[0][0]=17 and wptr at 1
        beat(2'b11, 0);
        beat(2'b00, 55);
        for (int i = 1; i <= 17; i++) beat(2'b01, i);
        send_vec(1, 0, 0, 0);
        wait_drained();
        check_got("wrap_col0", 8'd17, 8'd5, 8'd9, 8'd13);
        beat(2'b01, 100);
        send_vec(0, 1, 0, 0);
        wait_drained();
        check_got("wrap_col1", 8'd100, 8'd6, 8'd10, 8'd14);

        // Enable low freezes the core in IDLE and during COMPUTE
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 ena = 1'b1;
        send_vec(1, 2, 3, 4);
        repeat (3) @(posedge clk);
        #1 ena = 1'b0;
        @(negedge clk);
        check("ena_low_busy_kept", {63'd0, busy}, 64'd1);
        check("ena_low_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) @(posedge clk);
        #1 ena = 1'b1;
        measure_latency("latency_ena_gap", 20);
        wait_drained();
        check_got("ena_gap", e_242, 8'd70, 8'd110, e_150);

        // Back-pressure: hold each result 5 extra cycles before accepting it
        out_ready = 1'b0;
        send_vec(4, 3, 2, 1);
        for (int r = 0; r < 4; r++) begin
            int guard = 0;
            @(negedge clk);
            while (!out_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        check("stall_back_idle", {63'd0, busy}, 64'd0);
        check("stall_in_ready", {63'd0, in_ready}, 64'd1);
        check("stall_count", got_q.size(), 4);
        check("stall_none_left", exp_q.size(), 0);
        got_q.delete();
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Reset in the middle of COMPUTE aborts the job and clears W
        send_vec(1, 1, 1, 1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        got_q.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        send_vec(5, 6, 7, 8);
        wait_drained();
        check_got("after_reset", 8'd0, 8'd0, 8'd0, 8'd0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
